pipeline_run_monitor: RTL
=========================

# pipeline_run_monitor

- Synthesizable run-control and checking monitor that sits beside the pipelined RISC-V `Processor` in simulation and FPGA bring-up.
- Watches fetch PC, the ID-stage instruction and the write-back port, and keeps a shadow register file updated from write-back.
- Detects program end (ECALL or PC self-loop) or a cycle timeout, then freezes cycle/retire counters.
- Reports pass/fail from a designated result register, so benches stop relying on fixed run lengths and waveform inspection.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `CNT_W`, 32, cycle and retire counter width
- `MAX_CYCLES`, 1000, RUN+DRAIN cycles before timeout
- `PC_STALL_LIMIT`, 4, consecutive equal-PC cycles that mean self-loop halt
- `DRAIN_CYCLES`, 3, cycles waited after ECALL so older instructions reach WB
- `PASS_REG`, 10, shadow register checked at halt (a0)
- `PASS_VALUE`, 0, value in `PASS_REG` that means pass

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `pc_out` in XLEN: fetch PC
- `inst_id` in 32: instruction in ID
- `wb_valid` in 1: write-back occurs this cycle
- `wb_rd` in 5: destination register
- `wdata_wb` in XLEN: write-back data
- `dbg_raddr` in 5: shadow read address
- `dbg_rdata` out XLEN: shadow read data, registered
- `state` out 3: `run_state_t` encoding
- `done` out 1: state is HALTED or TIMEOUT
- `pass` out 1: HALTED and shadow[`PASS_REG`] == `PASS_VALUE`
- `fail` out 1: `done` and not `pass`
- `cycle_count` out CNT_W: cycles spent in RUN+DRAIN
- `retired_count` out CNT_W: `wb_valid` cycles in RUN+DRAIN

## Operation
- States: IDLE, RUN, DRAIN, HALTED, TIMEOUT.
- IDLE → RUN on the first clock edge with `reset`=0. All outputs, counters and the shadow file read 0 in IDLE.
- RUN → DRAIN when `inst_id` == 32'h0000_0073 (ECALL).
- RUN → HALTED when `pc_out` has been equal for `PC_STALL_LIMIT` consecutive sampled cycles. The compare counter restarts on any PC change.
- DRAIN → HALTED after exactly `DRAIN_CYCLES` cycles in DRAIN.
- RUN or DRAIN → TIMEOUT when `cycle_count` reaches `MAX_CYCLES`.
- If a halt condition and the timeout condition occur in the same cycle, the halt condition wins.
- HALTED and TIMEOUT are terminal until `reset`.
- Shadow file (32 × XLEN):
  - Written on `wb_valid` in RUN or DRAIN.
  - Writes with `wb_rd`=0 are discarded; x0 always reads 0.
  - Writes are ignored in terminal states.
- `retired_count` increments on every `wb_valid` in RUN/DRAIN, including rd=0.
- Counters are saturating at all-ones; they never wrap.
- `pass`/`fail` are evaluated from the shadow value at the moment of entering HALTED or TIMEOUT.

## Timing
- All outputs are registered and update one cycle after the causing input sample.
- `dbg_rdata`: one-cycle read latency. A same-cycle write to the read address returns the old value.
- `cycle_count` is 1 at the end of the first RUN cycle.
- `done` rises in the same cycle as `state` enters a terminal state.
- Reset asserted in any state: next edge → IDLE, with counters, PC-stall counter, drain counter and shadow file all cleared.

## Structure
- `run_monitor_pkg` holds:
  - `run_state_t` enum (IDLE=0, RUN=1, DRAIN=2, HALTED=3, TIMEOUT=4)
  - `RV_ECALL` = 32'h0000_0073
  - `RV_NUM_REGS` = 32
- One sub-module `shadow_regfile`: 32×XLEN, one write port with x0 suppression, one registered read port, synchronous clear.
- FSM, stall detector and counters live in the top.

## Test plan
- Reset held 3 cycles, then released:
  - During reset: `state`=IDLE, counts 0.
  - Next edge: RUN.
  - One edge later: `cycle_count`=1.
- Halt by ECALL:
  - Stimulus: WB x5=0x1234, WB x10=0, then ECALL in ID.
  - Response: DRAIN for 3 cycles, then HALTED with `pass`=1, `done`=1.
  - `dbg_raddr`=5 → `dbg_rdata`=0x1234 next cycle.
- WB to x0 with data 5:
  - Read x0 → 0.
  - `retired_count` still increments by 1.
- `pc_out` held at 0x40 for 4 cycles with x10=1 → HALTED, `pass`=0, `fail`=1.
- `MAX_CYCLES`=20, PC always changing, no ECALL:
  - TIMEOUT when `cycle_count`=20, `fail`=1.
  - Counters frozen for the following 10 cycles.
- Timeout and ECALL in the same cycle → DRAIN, not TIMEOUT.
- Reset asserted mid-DRAIN → IDLE, counters 0, shadow x10 reads 0.

Source files
------------

// File: rtl/pipeline_run_monitor_pkg.sv
// run_monitor_pkg: shared types and constants for pipeline_run_monitor.
//   run_state_t  - monitor FSM encoding, also driven out on the `state` port
//   RV_ECALL     - ECALL encoding; seeing it in ID starts the drain
//   RV_NUM_REGS  - architectural register count mirrored by the shadow file
package run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        HALTED  = 3'd3,
        TIMEOUT = 3'd4
    } run_state_t;

    localparam logic [31:0] RV_ECALL    = 32'h0000_0073;
    localparam int          RV_NUM_REGS = 32;
    localparam int          RV_REG_AW   = 5;

    function automatic logic is_terminal(input run_state_t s);
        return (s == HALTED) || (s == TIMEOUT);
    endfunction

endpackage

// File: rtl/pipeline_run_monitor_shadow_regfile.sv
// shadow_regfile: 32 x XLEN mirror of the core register file, fed from write-back.
//   clk, reset   - clock, synchronous active-high clear of every entry
//   we/waddr/wdata - write port; writes to x0 are dropped so x0 stays 0
//   raddr/rdata  - debug read port, one-cycle latency, returns pre-write value
//   tap_rdata    - combinational view of entry TAP_REG (pass/fail register)
module shadow_regfile
    import run_monitor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAP_REG = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [RV_REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [RV_REG_AW-1:0] raddr,
    output logic [XLEN-1:0]      rdata,
    output logic [XLEN-1:0]      tap_rdata
);

    localparam logic [RV_REG_AW-1:0] TAP_IDX = RV_REG_AW'(TAP_REG);

    logic [RV_NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [XLEN-1:0]                  rdata_q, rdata_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
        // Read from the current state, so a same-cycle write is not visible.
        rdata_d = regs_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q  <= '0;
            rdata_q <= '0;
        end else begin
            regs_q  <= regs_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign tap_rdata = regs_q[TAP_IDX];

endmodule

// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: run-control and self-check monitor for a pipelined RV core.
// Watches fetch PC, the ID instruction and write-back; ends the run on ECALL
// (after a drain), on a PC self-loop, or on a cycle timeout, then freezes the
// counters and reports pass/fail from shadow register PASS_REG.
//   clk, reset            - clock, synchronous active-high reset
//   pc_out, inst_id       - fetch PC and ID-stage instruction
//   wb_valid/wb_rd/wdata_wb - core write-back port
//   dbg_raddr/dbg_rdata   - shadow register read, one-cycle latency
//   state                 - run_state_t encoding
//   done/pass/fail        - run verdict, registered
//   cycle_count           - cycles spent in RUN+DRAIN (saturating)
//   retired_count         - wb_valid cycles in RUN+DRAIN (saturating)
module pipeline_run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CNT_W          = 32,
    parameter int MAX_CYCLES     = 1000,
    parameter int PC_STALL_LIMIT = 4,
    parameter int DRAIN_CYCLES   = 3,
    parameter int PASS_REG       = 10,
    parameter int PASS_VALUE     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pc_out,
    input  logic [31:0]          inst_id,
    input  logic                 wb_valid,
    input  logic [RV_REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]      wdata_wb,
    input  logic [RV_REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]      dbg_rdata,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     retired_count
);

    localparam int STALL_W = $clog2(PC_STALL_LIMIT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [RV_REG_AW-1:0] PASS_IDX = RV_REG_AW'(PASS_REG);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    logic             active;
    logic             wr_en;
    logic [CNT_W-1:0] cycle_inc;
    logic             timeout_hit;
    logic             ecall_hit;
    logic             pc_same;
    logic [STALL_W-1:0] stall_inc;
    logic             stall_hit;
    logic             drain_done;
    logic [XLEN-1:0]  pass_tap;
    logic [XLEN-1:0]  pass_src;

    assign active = (state_q == RUN) || (state_q == DRAIN);
    assign wr_en  = active && wb_valid;

    shadow_regfile #(
        .XLEN    (XLEN),
        .TAP_REG (PASS_REG)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .we        (wr_en),
        .waddr     (wb_rd),
        .wdata     (wdata_wb),
        .raddr     (dbg_raddr),
        .rdata     (dbg_rdata),
        .tap_rdata (pass_tap)
    );

    always_comb begin
        cycle_inc   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        timeout_hit = (cycle_inc >= CNT_W'(MAX_CYCLES));
        ecall_hit   = (inst_id == RV_ECALL);

        // A zero count means no PC has been sampled yet in this run.
        pc_same   = (stall_cnt_q != '0) && (pc_out == last_pc_q);
        stall_inc = !pc_same ? STALL_W'(1) :
                    (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
        stall_hit = (stall_inc >= STALL_W'(PC_STALL_LIMIT));

        drain_done = (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1));

        // The result register may be written on the very edge that ends
        // the run; judge the run on that value, not the stale one.
        pass_src = (wr_en && (wb_rd == PASS_IDX) && (wb_rd != '0)) ? wdata_wb : pass_tap;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = RUN;
            // Halt conditions are checked before the timeout so they win a tie.
            RUN: begin
                if (ecall_hit)        state_d = DRAIN;
                else if (stall_hit)   state_d = HALTED;
                else if (timeout_hit) state_d = TIMEOUT;
            end
            DRAIN: begin
                if (drain_done)       state_d = HALTED;
                else if (timeout_hit) state_d = TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        cycle_d     = active ? cycle_inc : cycle_q;
        retired_d   = retired_q;
        if (wr_en && (retired_q != '1)) begin
            retired_d = retired_q + 1'b1;
        end

        stall_cnt_d = '0;
        last_pc_d   = last_pc_q;
        if (state_q == RUN) begin
            stall_cnt_d = stall_inc;
            last_pc_d   = pc_out;
        end

        drain_cnt_d = '0;
        if ((state_q == DRAIN) && !drain_done) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end

        done_d = done_q;
        pass_d = pass_q;
        fail_d = fail_q;
        if (active) begin
            done_d = is_terminal(state_d);
            pass_d = (state_d == HALTED) && (pass_src == XLEN'(PASS_VALUE));
            fail_d = is_terminal(state_d) && !pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cycle_q     <= '0;
            retired_q   <= '0;
            stall_cnt_q <= '0;
            last_pc_q   <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
            last_pc_q   <= last_pc_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign state         = state_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule
